// File: rtl/operand_fetcher_pkg.sv
// rtl/operand_fetcher_pkg.sv - shared states, command field positions and sizes for operand_fetcher
package operand_fetcher_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int DATA_SIZE = 32;
    localparam int IDX_SIZE  = 6;
    localparam int OPCODE_W  = 6;

    // Command word layout
    localparam int CMD_OPCODE_LO = 26;
    localparam int CMD_SRC1_EN   = 25;
    localparam int CMD_S0_PTR    = 24;
    localparam int CMD_S1_PTR    = 23;
    localparam int CMD_SRC1_LO   = 12;
    localparam int CMD_SRC0_LO   = 6;
    localparam int CMD_DST_LO    = 0;

    typedef enum logic [3:0] {
        OF_IDLE  = 4'd0,
        OF_RD_S0 = 4'd1,
        OF_WT_S0 = 4'd2,
        OF_RD_P0 = 4'd3,
        OF_WT_P0 = 4'd4,
        OF_RD_S1 = 4'd5,
        OF_WT_S1 = 4'd6,
        OF_RD_P1 = 4'd7,
        OF_WT_P1 = 4'd8,
        OF_OUT   = 4'd9
    } of_state_e;

endpackage

// File: rtl/operand_fetcher_bus_read_port.sv
// rtl/operand_fetcher_bus_read_port.sv - one-shot read request issue and address-matched completion capture
module operand_fetcher_bus_read_port
    import operand_fetcher_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              rd_wait,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              disp_online,
    input  logic              read_dn,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              issue,
    output logic              capture,
    output logic              drive_addr
);

    logic              shot_q;
    logic [ADDR_W-1:0] pend_addr_q;

    // The request goes out once per grant; losing the grant or completing re-arms it
    always_ff @(posedge clk) begin
        if (rst) begin
            shot_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            if (!disp_online || capture) begin
                shot_q <= 1'b0;
            end else if (issue) begin
                shot_q <= 1'b1;
            end
            if (issue) begin
                pend_addr_q <= rd_addr;
            end
        end
    end

    assign drive_addr = rd_req && disp_online;
    assign issue      = rd_req && disp_online && !shot_q;
    assign capture    = rd_wait && read_dn && (bus_addr == pend_addr_q);

endmodule

// File: rtl/operand_fetcher.sv
// rtl/operand_fetcher.sv - decodes a command and reads its operands over the shared bus; OPERAND_INDIRECT_EN adds pointer reads
module operand_fetcher
    import operand_fetcher_pkg::*;
#(
    parameter int ADDR_W    = ADDR_SIZE,
    parameter int DATA_W    = DATA_SIZE,
    parameter int REG_IDX_W = IDX_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [31:0]         command,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                cmd_busy,
    input  logic                disp_online,
    inout  wire  [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output wire                 read_q,
    input  logic                read_dn,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   src0,
    output logic [DATA_W-1:0]   src1,
    output logic [ADDR_W-1:0]   dst_addr
);

    of_state_e state_q, state_d;

    logic [OPCODE_W-1:0]  opcode_q;
    logic                 src1_en_q;
    logic [REG_IDX_W-1:0] src0_idx_q, src1_idx_q;
    logic [ADDR_W-1:0]    base_q, dst_addr_q;
    logic [DATA_W-1:0]    src0_q, src1_q;

    logic              rd_req, rd_wait, issue, capture, drive_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              accept, handshake;
    of_state_e         after_src0;

`ifdef OPERAND_INDIRECT_EN
    logic s0_ptr_q, s1_ptr_q;
    wire  unused_cmd_bits = ^command[CMD_S1_PTR-1:CMD_SRC1_LO+REG_IDX_W];
`else
    wire  unused_cmd_bits = ^command[CMD_S0_PTR:CMD_SRC1_LO+REG_IDX_W];
`endif

    assign handshake  = op_valid && op_ready;
    assign accept     = cmd_valid && !cmd_busy;
    assign after_src0 = src1_en_q ? OF_RD_S1 : OF_OUT;

    operand_fetcher_bus_read_port #(.ADDR_W(ADDR_W)) u_port (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .rd_wait     (rd_wait),
        .rd_addr     (rd_addr),
        .disp_online (disp_online),
        .read_dn     (read_dn),
        .bus_addr    (addr),
        .issue       (issue),
        .capture     (capture),
        .drive_addr  (drive_addr)
    );

    assign addr   = drive_addr ? rd_addr : {ADDR_W{1'bz}};
    assign read_q = issue ? 1'b1 : 1'bz;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: each read waits for grant, then for its matching completion; a dropped grant re-issues
    always_comb begin
        state_d = state_q;
        case (state_q)
            OF_IDLE:  if (accept) state_d = OF_RD_S0;
            OF_RD_S0: if (issue)  state_d = OF_WT_S0;
            OF_WT_S0: begin
                if (capture) begin
`ifdef OPERAND_INDIRECT_EN
                    state_d = s0_ptr_q ? OF_RD_P0 : after_src0;
`else
                    state_d = after_src0;
`endif
                end else if (!disp_online) begin
                    state_d = OF_RD_S0;
                end
            end
            OF_RD_S1: if (issue)  state_d = OF_WT_S1;
            OF_WT_S1: begin
                if (capture) begin
`ifdef OPERAND_INDIRECT_EN
                    state_d = s1_ptr_q ? OF_RD_P1 : OF_OUT;
`else
                    state_d = OF_OUT;
`endif
                end else if (!disp_online) begin
                    state_d = OF_RD_S1;
                end
            end
`ifdef OPERAND_INDIRECT_EN
            OF_RD_P0: if (issue)  state_d = OF_WT_P0;
            OF_WT_P0: begin
                if (capture)           state_d = after_src0;
                else if (!disp_online) state_d = OF_RD_P0;
            end
            OF_RD_P1: if (issue)  state_d = OF_WT_P1;
            OF_WT_P1: begin
                if (capture)           state_d = OF_OUT;
                else if (!disp_online) state_d = OF_RD_P1;
            end
`endif
            OF_OUT:   if (handshake) state_d = accept ? OF_RD_S0 : OF_IDLE;
            default:  state_d = OF_IDLE;
        endcase
    end

    // Outputs and read-port controls decoded from state; busy drops in the handshake cycle for back-to-back accept
    always_comb begin
        rd_req   = 1'b0;
        rd_wait  = 1'b0;
        rd_addr  = '0;
        op_valid = (state_q == OF_OUT);
        cmd_busy = (state_q != OF_IDLE) && !(op_valid && op_ready);
        case (state_q)
            OF_RD_S0: begin
                rd_req  = 1'b1;
                rd_addr = base_q + ADDR_W'(src0_idx_q);
            end
            OF_RD_S1: begin
                rd_req  = 1'b1;
                rd_addr = base_q + ADDR_W'(src1_idx_q);
            end
            OF_WT_S0, OF_WT_S1: rd_wait = 1'b1;
`ifdef OPERAND_INDIRECT_EN
            OF_RD_P0: begin
                rd_req  = 1'b1;
                rd_addr = ADDR_W'(src0_q);
            end
            OF_RD_P1: begin
                rd_req  = 1'b1;
                rd_addr = ADDR_W'(src1_q);
            end
            OF_WT_P0, OF_WT_P1: rd_wait = 1'b1;
`endif
            default: ;
        endcase
    end

    // Command latch on accept and operand capture on each matching completion
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= '0;
            src1_en_q  <= 1'b0;
            src0_idx_q <= '0;
            src1_idx_q <= '0;
            base_q     <= '0;
            dst_addr_q <= '0;
            src0_q     <= '0;
            src1_q     <= '0;
`ifdef OPERAND_INDIRECT_EN
            s0_ptr_q   <= 1'b0;
            s1_ptr_q   <= 1'b0;
`endif
        end else if (accept) begin
            opcode_q   <= command[CMD_OPCODE_LO +: OPCODE_W];
            src1_en_q  <= command[CMD_SRC1_EN];
            src0_idx_q <= command[CMD_SRC0_LO +: REG_IDX_W];
            src1_idx_q <= command[CMD_SRC1_LO +: REG_IDX_W];
            base_q     <= base_addr;
            dst_addr_q <= base_addr + ADDR_W'(command[CMD_DST_LO +: REG_IDX_W]);
            src0_q     <= '0;
            src1_q     <= '0;
`ifdef OPERAND_INDIRECT_EN
            s0_ptr_q   <= command[CMD_S0_PTR];
            s1_ptr_q   <= command[CMD_S1_PTR];
`endif
        end else if (capture) begin
            case (state_q)
                OF_WT_S0: src0_q <= data;
                OF_WT_S1: src1_q <= data;
`ifdef OPERAND_INDIRECT_EN
                OF_WT_P0: src0_q <= data;
                OF_WT_P1: src1_q <= data;
`endif
                default: ;
            endcase
        end
    end

    // Upstream must never pulse cmd_valid while the stage is occupied
    always_ff @(posedge clk) begin
        if (!rst && cmd_valid) begin
            assert (!cmd_busy);
        end
    end

    assign opcode   = opcode_q;
    assign src0     = src0_q;
    assign src1     = src1_q;
    assign dst_addr = dst_addr_q;

endmodule
